// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code set 2 receiver that maps held piano keys to half-period divider counts.
// Optional PS2_PARITY_CHK_EN: when defined, frames with bad odd parity are rejected.
module ps2_note_decoder #(
  parameter int HALF_W      = 18,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [HALF_W-1:0] half_period,
  output logic              note_on,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);
`ifdef PS2_PARITY_CHK_EN
  localparam int SHIFT_W = 10;  // start, 8 data, parity
`else
  localparam int SHIFT_W = 9;   // parity is sampled but never stored
`endif

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_e;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall_edge;

  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               byte_valid_q, byte_valid_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               frame_err_q, frame_err_d;
  logic               frame_ok;

  state_e             state_q;
  logic [7:0]         held_q;
  logic               note_on_q;
  logic [HALF_W-1:0]  half_q;
  logic               tbl_hit;
  logic [HALF_W-1:0]  tbl_val;

  // NOTE: synchronizer flops reset to 1 (PS/2 idle level) so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_sync_q;

  // Stop bit is the live sample; start and parity come from the shift register.
`ifdef PS2_PARITY_CHK_EN
  assign frame_ok = ~shift_q[0] & data_sync_q & (^shift_q[9:1]);
`else
  assign frame_ok = ~shift_q[0] & data_sync_q;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    if (fall_edge) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          byte_valid_d = 1'b1;
          byte_data_d  = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        if (bit_cnt_q < 4'(SHIFT_W)) shift_d[bit_cnt_q] = data_sync_q;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_MAX) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = '0;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so register order never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    tbl_hit = 1'b1;
    tbl_val = '0;
    case (byte_data_q)
      8'h1C: tbl_val = HALF_W'(95555);
      8'h1B: tbl_val = HALF_W'(85132);
      8'h23: tbl_val = HALF_W'(75843);
      8'h2B: tbl_val = HALF_W'(71586);
      8'h34: tbl_val = HALF_W'(63776);
      8'h33: tbl_val = HALF_W'(56818);
      8'h3B: tbl_val = HALF_W'(50620);
      8'h42: tbl_val = HALF_W'(47778);
      default: tbl_hit = 1'b0;
    endcase
  end

  // Make/break tracking consumes the registered byte, so notes change 1 clk after byte_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      held_q    <= '0;
      note_on_q <= 1'b0;
      half_q    <= '0;
    end else if (byte_valid_q) begin
      case (state_q)
        IDLE: begin
          if (byte_data_q == 8'hF0)      state_q <= BREAK;
          else if (byte_data_q == 8'hE0) state_q <= EXT;
          else if (tbl_hit) begin
            held_q    <= byte_data_q;
            note_on_q <= 1'b1;
            half_q    <= tbl_val;
          end
        end
        BREAK: begin
          if (note_on_q && byte_data_q == held_q) begin
            note_on_q <= 1'b0;
            half_q    <= '0;
          end
          state_q <= IDLE;
        end
        EXT:       state_q <= (byte_data_q == 8'hF0) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign half_period = half_q;
  assign note_on     = note_on_q;
  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: frames, make/break tracking, errors, timeout and reset.
module tb_ps2_note_decoder;

  localparam int HALF = 20;  // system clocks per PS/2 clock half-period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [17:0] half_period;
  logic        note_on, byte_valid, frame_err;
  logic [7:0]  byte_data;

  int tests_run = 0;
  int tests_failed = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  ps2_note_decoder #(.HALF_W(18), .TIMEOUT_CYC(50000)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .half_period(half_period), .note_on(note_on), .byte_valid(byte_valid),
    .byte_data(byte_data), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      last_byte = byte_data;
    end
    if (frame_err) fe_cnt++;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (2 * HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic expect_note(input string name, input logic on, input logic [17:0] hp);
    tests_run++;
    if (note_on !== on || half_period !== hp) begin
      tests_failed++;
      $display("FAIL %s: note_on=%0b half_period=%0d, expected note_on=%0b half_period=%0d",
               name, note_on, half_period, on, hp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_note("reset_note", 1'b0, 18'd0);
    tests_run++;
    if ({byte_valid, frame_err, byte_data} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_bytes: bv=%0b fe=%0b data=%02h, expected 0 0 00",
               byte_valid, frame_err, byte_data);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_note();
    int bv0;
    bv0 = bv_cnt;
    send_byte(8'h1C);
    tests_run++;
    if (bv_cnt !== bv0 + 1 || last_byte !== 8'h1C) begin
      tests_failed++;
      $display("FAIL single_byte: %0d bytes last=%02h, expected 1 byte 1c", bv_cnt - bv0, last_byte);
    end
    expect_note("single_note", 1'b1, 18'd95555);
  endtask

  task automatic test_typematic();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h1C);
      expect_note("typematic_hold", 1'b1, 18'd95555);
    end
    send_byte(8'hF0);
    expect_note("typematic_f0", 1'b1, 18'd95555);
    send_byte(8'h1C);
    expect_note("typematic_break", 1'b0, 18'd0);
  endtask

  task automatic test_last_key_wins();
    send_byte(8'h15);
    expect_note("unmapped_make", 1'b0, 18'd0);
    send_byte(8'h1C);
    send_byte(8'h42);
    expect_note("last_key_42", 1'b1, 18'd47778);
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_note("stale_break", 1'b1, 18'd47778);
    send_byte(8'hF0);
    send_byte(8'h42);
    expect_note("break_42", 1'b0, 18'd0);
  endtask

  task automatic test_frame_errors();
    int bv0, fe0;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h23, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHK_EN
    tests_run++;
    if (fe_cnt !== fe0 + 1 || bv_cnt !== bv0) begin
      tests_failed++;
      $display("FAIL parity_err: fe=%0d bv=%0d, expected fe=1 bv=0", fe_cnt - fe0, bv_cnt - bv0);
    end
    expect_note("parity_err_note", 1'b0, 18'd0);
`else
    tests_run++;
    if (fe_cnt !== fe0 || bv_cnt !== bv0 + 1 || last_byte !== 8'h23) begin
      tests_failed++;
      $display("FAIL parity_ignored: fe=%0d bv=%0d last=%02h, expected fe=0 bv=1 last=23",
               fe_cnt - fe0, bv_cnt - bv0, last_byte);
    end
    expect_note("parity_ignored_note", 1'b1, 18'd75843);
    send_byte(8'hF0);
    send_byte(8'h23);
    expect_note("parity_release", 1'b0, 18'd0);
`endif
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    tests_run++;
    if (fe_cnt !== fe0 + 1 || bv_cnt !== bv0) begin
      tests_failed++;
      $display("FAIL stop_err: fe=%0d bv=%0d, expected fe=1 bv=0", fe_cnt - fe0, bv_cnt - bv0);
    end
    expect_note("stop_err_note", 1'b0, 18'd0);
  endtask

  task automatic test_timeout();
    int fe0, bv0;
    fe0 = fe_cnt;
    bv0 = bv_cnt;
    send_frame(8'h34, 1'b0, 1'b1, 5);
    repeat (48000) @(negedge clk);
    tests_run++;
    if (fe_cnt !== fe0) begin
      tests_failed++;
      $display("FAIL timeout_early: fe=%0d, expected 0", fe_cnt - fe0);
    end
    repeat (2500) @(negedge clk);
    tests_run++;
    if (fe_cnt !== fe0 + 1 || bv_cnt !== bv0) begin
      tests_failed++;
      $display("FAIL timeout_fire: fe=%0d bv=%0d, expected fe=1 bv=0", fe_cnt - fe0, bv_cnt - bv0);
    end
    send_byte(8'h34);
    expect_note("after_timeout", 1'b1, 18'd63776);
    send_byte(8'hF0);
    send_byte(8'h34);
    expect_note("after_timeout_release", 1'b0, 18'd0);
  endtask

  task automatic test_extended_and_reset();
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'h1C);
    expect_note("ext_make", 1'b1, 18'd95555);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_note("ext_break", 1'b1, 18'd95555);
    send_byte(8'h1B);
    expect_note("ext_back_idle", 1'b1, 18'd85132);
    rst_n = 1'b0;
    #1;
    expect_note("reset_mid_note", 1'b0, 18'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int fe0, bv0;
    send_frame(8'h42, 1'b0, 1'b1, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fe0 = fe_cnt;
    bv0 = bv_cnt;
    send_byte(8'h1C);
    tests_run++;
    if (fe_cnt !== fe0 || bv_cnt !== bv0 + 1 || last_byte !== 8'h1C) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: fe=%0d bv=%0d last=%02h, expected fe=0 bv=1 last=1c",
               fe_cnt - fe0, bv_cnt - bv0, last_byte);
    end
    expect_note("reset_mid_frame_note", 1'b1, 18'd95555);
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_typematic();
    test_last_key_wins();
    test_frame_errors();
    test_timeout();
    test_extended_and_reset();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
